// File: rtl/acc_cpu.sv
// Accumulator CPU: one instruction per FETCH/DECODE/EXECUTE pass, with an internal data memory.
// Optional debug read port on the data memory is enabled with ACC_CPU_DBG_PORT_EN.
module acc_cpu #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int OP_W   = 4,
    parameter int PC_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [PC_W-1:0]          imem_addr,
    input  logic                     imem_ack,
    input  logic [OP_W+ADDR_W-1:0]   imem_data,
    output logic [DATA_W-1:0]        acc,
    output logic                     flag_z,
    output logic                     flag_c,
    output logic                     halted
`ifdef ACC_CPU_DBG_PORT_EN
    ,
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        dbg_data
`endif
);

    // state    | meaning
    // S_FETCH  | imem_req high, wait for imem_ack, capture ir, pc+1
    // S_DECODE | single bubble cycle, operand read settles
    // S_EXECUTE| update acc/flags/memory/pc, go to FETCH or HALT
    // S_HALT   | frozen until reset
    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXECUTE, S_HALT} state_t;

    localparam logic [OP_W-1:0] OP_LDA  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_STA  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_JZ   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_JMP  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_NOP  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_MOVI = OP_W'(8);
    localparam logic [OP_W-1:0] OP_NAND = OP_W'(9);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(10);
    localparam logic [OP_W-1:0] OP_NOR  = OP_W'(11);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(12);
    localparam logic [OP_W-1:0] OP_ADC  = OP_W'(13);
    localparam logic [OP_W-1:0] OP_JC   = OP_W'(14);
    localparam logic [OP_W-1:0] OP_HLT  = OP_W'(15);

    localparam int WIDE_W = DATA_W + ADDR_W + PC_W;

    state_t                   state_q, state_d;
    logic [PC_W-1:0]          pc_q, pc_d;
    logic [OP_W+ADDR_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]        acc_q, acc_d;
    logic                     z_q, z_d;
    logic                     c_q, c_d;
    logic                     halted_q, halted_d;
    logic                     run_q;
    logic                     mem_we;
    logic                     acc_wr;

    logic [DATA_W-1:0]        mem_q [0:(1<<ADDR_W)-1];

    logic [OP_W-1:0]          op;
    logic [ADDR_W-1:0]        x;
    logic [WIDE_W-1:0]        x_wide;
    logic [DATA_W-1:0]        x_data;
    logic [PC_W-1:0]          x_pc;
    logic [DATA_W-1:0]        mem_rd;
    logic [DATA_W:0]          sum;
    logic [DATA_W:0]          diff;

    assign op     = ir_q[OP_W+ADDR_W-1:ADDR_W];
    assign x      = ir_q[ADDR_W-1:0];
    assign x_wide = WIDE_W'(x);
    assign x_data = x_wide[DATA_W-1:0];
    assign x_pc   = x_wide[PC_W-1:0];
    assign mem_rd = mem_q[x];

    assign sum  = {1'b0, acc_q} + {1'b0, mem_rd} + {{DATA_W{1'b0}}, (op == OP_ADC) & c_q};
    assign diff = {1'b0, acc_q} - {1'b0, mem_rd};

    // run_q keeps imem_req low while reset is held and for the edge it is released on
    assign imem_req  = run_q && (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign acc       = acc_q;
    assign flag_z    = z_q;
    assign flag_c    = c_q;
    assign halted    = halted_q;

`ifdef ACC_CPU_DBG_PORT_EN
    assign dbg_data = mem_q[dbg_addr];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            acc_q    <= '0;
            z_q      <= 1'b1;
            c_q      <= 1'b0;
            halted_q <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            acc_q    <= acc_d;
            z_q      <= z_d;
            c_q      <= c_d;
            halted_q <= halted_d;
            run_q    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[x] <= acc_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        acc_d    = acc_q;
        z_d      = z_q;
        c_d      = c_q;
        halted_d = halted_q;
        mem_we   = 1'b0;
        acc_wr   = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (imem_req && imem_ack) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                case (op)
                    OP_LDA:  begin acc_d = mem_rd;               acc_wr = 1'b1; end
                    OP_STA:  mem_we = 1'b1;
                    OP_AND:  begin acc_d = acc_q & mem_rd;       acc_wr = 1'b1; end
                    OP_ADD, OP_ADC: begin
                        acc_d  = sum[DATA_W-1:0];
                        c_d    = sum[DATA_W];
                        acc_wr = 1'b1;
                    end
                    OP_SUB: begin
                        acc_d  = diff[DATA_W-1:0];
                        c_d    = diff[DATA_W];
                        acc_wr = 1'b1;
                    end
                    OP_JZ:   if (z_q) pc_d = x_pc;
                    OP_JMP:  pc_d = x_pc;
                    OP_NOP:  ;
                    OP_MOVI: begin acc_d = x_data;               acc_wr = 1'b1; end
                    OP_NAND: begin acc_d = ~(acc_q & mem_rd);    acc_wr = 1'b1; end
                    OP_OR:   begin acc_d = acc_q | mem_rd;       acc_wr = 1'b1; end
                    OP_NOR:  begin acc_d = ~(acc_q | mem_rd);    acc_wr = 1'b1; end
                    OP_XOR:  begin acc_d = acc_q ^ mem_rd;       acc_wr = 1'b1; end
                    OP_JC:   if (c_q) pc_d = x_pc;
                    OP_HLT: begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end
                    default: ;
                endcase
                if (acc_wr) begin
                    z_d = (acc_d == '0);
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_acc_cpu.sv
// Bench for acc_cpu: directed scenarios plus random instruction stream against an ISA-level model.
module tb_acc_cpu;

    logic       clk;
    logic       rst;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [7:0] acc;
    logic       flag_z;
    logic       flag_c;
    logic       halted;

    logic       rst2;
    logic       imem_req2;
    logic [3:0] imem_addr2;
    logic       imem_ack2;
    logic [7:0] imem_data2;
    logic [7:0] acc2;
    logic       flag_z2;
    logic       flag_c2;
    logic       halted2;

`ifdef ACC_CPU_DBG_PORT_EN
    logic [3:0] dbg_addr;
    logic [7:0] dbg_data;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int m_acc, m_z, m_c, m_pc, m_halted;
    int m_mem [16];

    acc_cpu #(.DATA_W(8), .ADDR_W(4), .OP_W(4), .PC_W(8)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .acc(acc), .flag_z(flag_z), .flag_c(flag_c), .halted(halted)
`ifdef ACC_CPU_DBG_PORT_EN
        , .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`endif
    );

    acc_cpu #(.DATA_W(8), .ADDR_W(4), .OP_W(4), .PC_W(4)) dut_pc4 (
        .clk(clk), .rst(rst2),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack2), .imem_data(imem_data2),
        .acc(acc2), .flag_z(flag_z2), .flag_c(flag_c2), .halted(halted2)
`ifdef ACC_CPU_DBG_PORT_EN
        , .dbg_addr(4'd0), .dbg_data()
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ISA-level reference: one instruction's architectural effect
    task automatic model_exec(input int op, input int x);
        int m, s;
        m = m_mem[x];
        case (op)
            0:  begin m_acc = m;                 m_z = (m_acc == 0); end
            1:  m_mem[x] = m_acc;
            2:  begin m_acc = m_acc & m;         m_z = (m_acc == 0); end
            3:  begin s = m_acc + m; m_c = (s > 255); m_acc = s % 256; m_z = (m_acc == 0); end
            4:  begin m_c = (m_acc < m); m_acc = (m_acc - m + 256) % 256; m_z = (m_acc == 0); end
            5:  if (m_z != 0) m_pc = x;
            6:  m_pc = x;
            7:  ;
            8:  begin m_acc = x;                 m_z = (m_acc == 0); end
            9:  begin m_acc = 255 - (m_acc & m); m_z = (m_acc == 0); end
            10: begin m_acc = m_acc | m;         m_z = (m_acc == 0); end
            11: begin m_acc = 255 - (m_acc | m); m_z = (m_acc == 0); end
            12: begin m_acc = m_acc ^ m;         m_z = (m_acc == 0); end
            13: begin s = m_acc + m + m_c; m_c = (s > 255); m_acc = s % 256; m_z = (m_acc == 0); end
            14: if (m_c != 0) m_pc = x;
            default: m_halted = 1;
        endcase
    endtask

    task automatic exec_one(input int op, input int x, input int dly);
        logic [7:0] a0;
        chk("fetch_req", imem_req, 1);
        chk("fetch_addr", imem_addr, m_pc);
        a0 = imem_addr;
        imem_ack = 1'b0;
        for (int i = 0; i < dly; i++) begin
            imem_data = 8'($urandom);
            @(negedge clk); cyc++;
            chk("wait_req", imem_req, 1);
            chk("wait_addr", imem_addr, a0);
        end
        imem_ack  = 1'b1;
        imem_data = 8'((op << 4) | x);
        @(negedge clk); cyc++;
        chk("decode_req", imem_req, 0);
        m_pc = (m_pc + 1) % 256;
        model_exec(op, x);
        imem_ack = 1'($urandom_range(0, 1)); imem_data = 8'($urandom);
        @(negedge clk); cyc++;
        imem_ack = 1'($urandom_range(0, 1)); imem_data = 8'($urandom);
        @(negedge clk); cyc++;
        imem_ack = 1'b0;
        chk("acc", acc, m_acc);
        chk("flag_z", flag_z, m_z);
        chk("flag_c", flag_c, m_c);
        chk("halted", halted, m_halted);
        if (m_halted != 0) begin
            chk("halt_req", imem_req, 0);
        end else begin
            chk("next_req", imem_req, 1);
            chk("next_addr", imem_addr, m_pc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_acc", acc, 0);
        chk("rst_z", flag_z, 1);
        chk("rst_c", flag_c, 0);
        chk("rst_halted", halted, 0);
        m_acc = 0; m_z = 1; m_c = 0; m_pc = 0; m_halted = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_req", imem_req, 1);
        chk("rel_addr", imem_addr, 0);
    endtask

    task automatic idle_halted(input int n);
        for (int i = 0; i < n; i++) begin
            imem_ack = 1'($urandom_range(0, 1)); imem_data = 8'($urandom);
            @(negedge clk);
            chk("hlt_req", imem_req, 0);
            chk("hlt_halted", halted, 1);
            chk("hlt_acc", acc, m_acc);
            chk("hlt_z", flag_z, m_z);
            chk("hlt_c", flag_c, m_c);
        end
        imem_ack = 1'b0;
    endtask

    initial begin
        int pc_before, exp2, fetches2;
        rst = 1'b1; rst2 = 1'b1;
        imem_ack = 1'b0; imem_data = 8'h00;
        imem_ack2 = 1'b1; imem_data2 = 8'h70;
`ifdef ACC_CPU_DBG_PORT_EN
        dbg_addr = 4'd0;
`endif
        for (int i = 0; i < 16; i++) m_mem[i] = 0;
        @(negedge clk);
        rst2 = 1'b0;
        do_reset();

        // MOVI 5; STA 3; ADD 3; HLT in 12 cycles
        cyc = 0;
        exec_one(8, 5, 0);
        exec_one(1, 3, 0);
        exec_one(3, 3, 0);
        exec_one(15, 0, 0);
        chk("prog_cycles", cyc, 12);
        chk("prog_acc", acc, 10);
        chk("prog_z", flag_z, 0);
        chk("prog_c", flag_c, 0);
        chk("prog_halted", halted, 1);
        idle_halted(4);

        // reset out of HALT, memory survives
        do_reset();
        exec_one(0, 3, 0);
        chk("mem3_kept", acc, 5);

        // preload every memory word
        for (int a = 0; a < 16; a++) begin
            exec_one(8, $urandom_range(0, 15), $urandom_range(0, 1));
            exec_one(1, a, $urandom_range(0, 1));
        end
`ifdef ACC_CPU_DBG_PORT_EN
        dbg_addr = 4'd3; #1;
        chk("dbg_data", dbg_data, m_mem[3]);
`endif

        // 0xFF + 1 then ADC 1
        exec_one(8, 1, 0); exec_one(1, 1, 0);
        exec_one(8, 0, 0); exec_one(4, 1, 0);
        chk("ff_acc", acc, 8'hFF);
        exec_one(3, 1, 0);
        chk("add_acc", acc, 0); chk("add_c", flag_c, 1); chk("add_z", flag_z, 1);
        exec_one(13, 1, 0);
        chk("adc_acc", acc, 2); chk("adc_c", flag_c, 0); chk("adc_z", flag_z, 0);

        // SUB borrow drives JC
        exec_one(8, 3, 0); exec_one(1, 2, 0);
        exec_one(8, 2, 0); exec_one(4, 2, 0);
        chk("sub_acc", acc, 8'hFF); chk("sub_c", flag_c, 1);
        exec_one(14, 9, 0);
        chk("jc_taken", imem_addr, 9);
        exec_one(8, 1, 0); exec_one(1, 2, 0);
        exec_one(8, 2, 0); exec_one(4, 2, 0);
        chk("sub2_c", flag_c, 0);
        pc_before = m_pc;
        exec_one(14, 9, 0);
        chk("jc_not_taken", imem_addr, (pc_before + 1) % 256);

        // 4-cycle ack wait
        cyc = 0;
        exec_one(8, 7, 4);
        chk("wait_cycles", cyc, 7);
        chk("wait_acc", acc, 7);

        // reset mid-fetch
        @(negedge clk); @(negedge clk);
        chk("midfetch_req", imem_req, 1);
        do_reset();
        exec_one(0, 2, 0);
        chk("mem2_kept", acc, m_mem[2]);

        // random instruction stream
        for (int n = 0; n < 200; n++) begin
            exec_one($urandom_range(0, 14), $urandom_range(0, 15), $urandom_range(0, 2));
        end

        // PC_W=4 instance running NOPs wraps 15 -> 0
        exp2 = 0; fetches2 = 0;
        rst2 = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (imem_req2) begin
                chk("pc4_addr", imem_addr2, exp2);
                exp2 = (exp2 + 1) % 16;
                fetches2++;
            end
        end
        chk("pc4_fetches", fetches2, 20);
        chk("pc4_acc", acc2, 0);
        chk("pc4_z", flag_z2, 1);
        chk("pc4_c", flag_c2, 0);
        chk("pc4_halted", halted2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
